axis_window3x3_stream: RTL
==========================

Name: axis_window3x3_stream

Overview:
- Consumes the upsampled feature-map stream produced by the upsample DMA/BRAM stage, one channel plane at a time, raster order.
- Emits one zero-padded 3x3 neighbourhood per pixel, centre-pixel raster order, for the following 3x3 convolution stage.
- Uses two on-chip line buffers and a 3x3 register window.
- Handles per-plane size selection, AXI-Stream back-pressure on both sides, and end-of-plane flush.

Parameters:
- DATA_WIDTH, 16, pixel width in bits.
- MAX_W, 128, line-buffer depth; must be at least the largest plane width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin one plane; ignored unless idle
- size_sel  in  3  plane size, latched at start; W=H=8<<size_sel (0..4 -> 8..128); values >4 treated as 0
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last window handshake
- frame_err  out  1  sticky tlast mismatch flag; cleared by start
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  marks the last pixel of the plane
- m_axis_tdata  out  9*DATA_WIDTH  window; tap i at [i*DATA_WIDTH +: DATA_WIDTH]; i=0 top-left, i=4 centre, i=8 bottom-right, row-major
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  high on the last window of the plane

Behaviour:
- Reset: busy=0, done=0, frame_err=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, FSM=IDLE, all counters 0. Line-buffer RAM is not cleared; padding is derived from counters, not from RAM contents.
- N=W*H. Position counter k runs 0..N+W, giving N+W+1 positions per plane.
- For k<N, a position is one input pixel taken by the s_axis handshake. For k>=N, it is an internally injected zero (flush); no s_axis handshake occurs.
- Each position shifts the window, updates both line buffers at column k mod W, and advances column/row counters.
- Positions with k>=W+1 produce the window centred on pixel k-(W+1).
- Zero padding: a tap is forced to 0 if its row <0 or >=H, or its column <0 or >=W. Padding is applied to the output only, never to buffered data. Row wrap must not leak data from the previous row.
- FSM states:
  - IDLE: accepts start; latches size_sel; clears frame_err and counters; goes to RUN.
  - RUN: consumes positions k<N; goes to FLUSH when k=N.
  - FLUSH: injects positions N..N+W; goes to DRAIN.
  - DRAIN: waits for the final output handshake; pulses done; returns to IDLE.
- A position advances only when the output register is free: advance = (!m_axis_tvalid || m_axis_tready) && (RUN ? s_axis_tvalid : FLUSH).
- s_axis_tready = RUN && (!m_axis_tvalid || m_axis_tready). It is combinational on m_axis_tready; no combinational path from s_axis_tvalid to any ready.
- Latency: m_axis_tvalid asserts on the clock edge that consumes position W+1. Sustained throughput is 1 window/cycle when both sides are always ready.
- m_axis_tdata and m_axis_tvalid stay stable while m_axis_tvalid && !m_axis_tready.
- m_axis_tlast accompanies window N-1 only.
- frame_err sets if s_axis_tlast=1 on any k!=N-1, or s_axis_tlast=0 at k=N-1. On error, counting proceeds by position and exactly N windows are still emitted.
- start while busy: ignored. start and rst in the same cycle: rst wins.
- Reset mid-plane returns to IDLE within one cycle and drops m_axis_tvalid; the partial window is discarded.
- Exactly N output handshakes occur per plane for every size.

Test Plan:
- 8x8 ramp (size_sel=0, pixel(r,c)=8r+c+1), both sides always ready -> 64 windows. Window0 = {0,0,0,0,1,2,0,9,10}. Window9 (centre 10) = {1,2,3,9,10,11,17,18,19}. Window63 = {55,56,0,63,64,0,0,0,0} with tlast=1. done one cycle after its handshake; first valid after the 10th input handshake.
- Same ramp with random tvalid gaps and m_axis_tready toggling about 50% -> identical 64-window sequence; tdata held stable during every stall; frame_err=0.
- size_sel=4 (128x128), pixel = (r*128+c) mod 65536 -> 16384 windows. Check window 127 and window 128 have no column-wrap leakage (taps 2,5,8 = 0 at c=127; taps 0,3,6 = 0 at c=0).
- size_sel=0 with tlast asserted on pixel 40 and not on pixel 63 -> frame_err=1 by pixel 40 and stays high; still 64 windows; next start clears frame_err.
- rst asserted at input pixel 30 of an 8x8 plane, then start again with a new ramp -> no stale windows; second plane output is bit-exact with the first test.
- start pulse at mid-plane -> ignored, busy stays 1, output count unchanged; size_sel=7 at start -> behaves as 8x8.

Source files
------------

// File: rtl/axis_window3x3_stream.sv
// axis_window3x3_stream
// Turns a raster-order pixel stream (one square channel plane) into one
// zero-padded 3x3 neighbourhood per pixel, emitted in centre-pixel raster order.
// Two line buffers hold the previous two rows. A 3x3 register window shifts one
// column per position. A flush phase of W+1 injected zeros pushes out the final
// windows. Padding is computed from the centre-pixel counters, so stale
// line-buffer contents never reach the output.
module axis_window3x3_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_W      = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              size_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_err,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [9*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int AW = $clog2(MAX_W);
    localparam int CW = AW + 1;
    localparam int KW = 2 * CW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           w_q;
    logic [KW-1:0]           n_q;
    logic [KW-1:0]           k_q;
    logic [CW-1:0]           col_q;
    logic [CW-1:0]           cc_q;
    logic [CW-1:0]           cr_q;
    logic                    busy_q, done_q, err_q;
    logic                    m_valid_q, m_last_q;
    logic [9*DATA_WIDTH-1:0] m_data_q;

    logic [DATA_WIDTH-1:0]   lb0_q [MAX_W];
    logic [DATA_WIDTH-1:0]   lb1_q [MAX_W];
    logic [DATA_WIDTH-1:0]   win_q [3][3];
    logic [DATA_WIDTH-1:0]   win_d [3][3];
    logic [9*DATA_WIDTH-1:0] win_masked;

    logic                    out_free, advance, emit, last_pos, drain_hs, accept_start;
    logic [DATA_WIDTH-1:0]   pix_in, lb0_rd, lb1_rd;
    logic [AW-1:0]           col_idx;
    logic [2:0]              sel_eff;
    logic [CW-1:0]           w_start;
    logic [KW-1:0]           n_start;

    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_err     = err_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;

    assign out_free      = !m_valid_q || m_axis_tready;
    assign s_axis_tready = (state_q == S_RUN) && out_free;
    assign advance       = out_free && ((state_q == S_RUN) ? s_axis_tvalid : (state_q == S_FLUSH));
    assign emit          = advance && (k_q >= (KW'(w_q) + KW'(1)));
    assign last_pos      = (k_q == (n_q + KW'(w_q)));
    assign drain_hs      = (state_q == S_DRAIN) && m_valid_q && m_axis_tready;
    assign accept_start  = (state_q == S_IDLE) && start;
    assign pix_in        = (state_q == S_RUN) ? s_axis_tdata : '0;
    assign col_idx       = col_q[AW-1:0];
    assign lb0_rd        = lb0_q[col_idx];
    assign lb1_rd        = lb1_q[col_idx];
    assign sel_eff       = (size_sel > 3'd4) ? 3'd0 : size_sel;
    assign w_start       = CW'(8) << sel_eff;
    assign n_start       = KW'(w_start) * KW'(w_start);

    // Next-state logic for the plane sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN; else state_d = S_IDLE;
            S_RUN:   if (advance && (k_q == n_q - KW'(1))) state_d = S_FLUSH; else state_d = S_RUN;
            S_FLUSH: if (advance && last_pos) state_d = S_DRAIN; else state_d = S_FLUSH;
            S_DRAIN: if (drain_hs) state_d = S_IDLE; else state_d = S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Window after this position's shift: new right column is {row-2, row-1, current}
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
            win_d[r][2] = '0;
        end
        win_d[0][2] = lb1_rd;
        win_d[1][2] = lb0_rd;
        win_d[2][2] = pix_in;
    end

    // Zero any tap that falls outside the plane around the current centre pixel
    always_comb begin
        win_masked = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (((r == 0) && (cr_q == CW'(0))) || ((r == 2) && (cr_q == w_q - CW'(1))) ||
                    ((c == 0) && (cc_q == CW'(0))) || ((c == 2) && (cc_q == w_q - CW'(1)))) begin
                    win_masked[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    win_masked[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
                end
            end
        end
    end

    // Line buffers: row-1 moves to row-2, the current pixel becomes row-1
    always_ff @(posedge clk) begin
        if (advance) begin
            lb1_q[col_idx] <= lb0_rd;
            lb0_q[col_idx] <= pix_in;
        end
    end

    // 3x3 register window shift
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (advance) begin
            win_q <= win_d;
        end
    end

    // Plane counters, status flags and the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q       <= CW'(8);
            n_q       <= KW'(64);
            k_q       <= '0;
            col_q     <= '0;
            cc_q      <= '0;
            cr_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            done_q <= drain_hs;
            if (accept_start) begin
                w_q    <= w_start;
                n_q    <= n_start;
                k_q    <= '0;
                col_q  <= '0;
                cc_q   <= '0;
                cr_q   <= '0;
                err_q  <= 1'b0;
                busy_q <= 1'b1;
            end else begin
                if (advance) begin
                    k_q   <= k_q + KW'(1);
                    col_q <= (col_q == w_q - CW'(1)) ? CW'(0) : col_q + CW'(1);
                    if ((state_q == S_RUN) && (s_axis_tlast != (k_q == n_q - KW'(1)))) begin
                        err_q <= 1'b1;
                    end
                end
                if (drain_hs) begin
                    busy_q <= 1'b0;
                end
            end
            if (emit) begin
                m_data_q <= win_masked;
                m_last_q <= last_pos;
                if (cc_q == w_q - CW'(1)) begin
                    cc_q <= '0;
                    cr_q <= cr_q + CW'(1);
                end else begin
                    cc_q <= cc_q + CW'(1);
                end
            end
            if (emit) begin
                m_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule
